// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: drives a gate-level 4-bit universal shift register
// (the RUC) one step at a time. It takes one host command at a time (load,
// shift left, shift right, rotate) and inserts settle cycles after every
// enable pulse so the RUC's gate delays resolve before the next step.
// Completion is signalled with a one-cycle done pulse, along with the step
// count and the final Q.
module shift_reg_sequencer #(
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned CNT_W      = 3
) (
    input  logic             CLK,
    input  logic             RST_L,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [3:0]       cmd_data,
    input  logic             cmd_sin,
    output logic             ENB,
    output logic             DIR,
    output logic [1:0]       MODO,
    output logic [3:0]       D,
    output logic             S_IN,
    input  logic [3:0]       Q,
    input  logic             S_OUT,
    output logic             done,
    output logic             busy,
    output logic [3:0]       result,
    output logic [CNT_W-1:0] steps_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        SETTLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHL  = 2'b01,
        OP_SHR  = 2'b10,
        OP_ROT  = 2'b11
    } op_t;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t           state_q, state_d;
    op_t              op_q;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] step_q;
    logic [3:0]       settle_q;
    logic [3:0]       d_q;
    logic             dir_q;
    logic             sin_q;
    logic [3:0]       result_q;
    logic [CNT_W-1:0] steps_q;

    logic             accept;
    logic             more_after_step;
    logic             more_remaining;
    op_t              cmd_op_e;

    // S_OUT is reserved on the RUC interface and not consumed here.
    logic             unused_sout;
    assign unused_sout = S_OUT;

    assign cmd_op_e = op_t'(cmd_op);

    // Next-state decode and handshake acceptance.
    always_comb begin
        state_d         = state_q;
        accept          = 1'b0;
        more_after_step = (step_q + CNT_ONE) < target_q;
        more_remaining  = step_q < target_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_op_e == OP_LOAD || cmd_count != '0) begin
                        state_d = STEP;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            STEP: begin
                if (SETTLE_CYC != 0) begin
                    state_d = SETTLE;
                end else if (more_after_step) begin
                    state_d = STEP;
                end else begin
                    state_d = FINISH;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = more_remaining ? STEP : FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch, step/settle counters and completion capture.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            op_q     <= OP_LOAD;
            target_q <= '0;
            step_q   <= '0;
            settle_q <= '0;
            d_q      <= '0;
            dir_q    <= 1'b0;
            sin_q    <= 1'b0;
            result_q <= '0;
            steps_q  <= '0;
        end else begin
            if (accept) begin
                op_q     <= cmd_op_e;
                target_q <= (cmd_op_e == OP_LOAD) ? CNT_ONE : cmd_count;
                step_q   <= '0;
                settle_q <= '0;
                dir_q    <= (cmd_op_e == OP_SHR);
                sin_q    <= (cmd_op_e == OP_SHL || cmd_op_e == OP_SHR) ? cmd_sin : 1'b0;
                if (cmd_op_e == OP_LOAD) begin
                    d_q <= cmd_data;
                end
            end
            if (state_q == STEP) begin
                step_q   <= step_q + CNT_ONE;
                settle_q <= '0;
            end
            if (state_q == SETTLE) begin
                settle_q <= settle_q + 4'd1;
            end
            if (state_q == FINISH) begin
                result_q <= Q;
                steps_q  <= step_q;
            end
        end
    end

    // RUC control pins and host status. Result and step count follow Q and
    // the live counter during FINISH so they are valid alongside done, even
    // when no settle cycle separates the last enable from completion.
    always_comb begin
        cmd_ready  = (state_q == IDLE);
        ENB        = (state_q == STEP);
        busy       = (state_q == STEP) || (state_q == SETTLE);
        done       = (state_q == FINISH);
        DIR        = dir_q;
        D          = d_q;
        S_IN       = sin_q;
        MODO       = 2'b00;
        if (state_q == STEP) begin
            case (op_q)
                OP_LOAD: MODO = 2'b11;
                OP_SHL:  MODO = 2'b01;
                OP_SHR:  MODO = 2'b01;
                OP_ROT:  MODO = 2'b10;
                default: MODO = 2'b00;
            endcase
        end
        result     = (state_q == FINISH) ? Q : result_q;
        steps_done = (state_q == FINISH) ? step_q : steps_q;
    end

endmodule

// File: doc/shift_reg_sequencer.md
Name: shift_reg_sequencer

Overview:
- Sequences the gate-level 4-bit universal shift register (register under control, RUC).
- Accepts one command at a time from a host over a valid/ready handshake: parallel load, shift left, shift right or rotate, each by N steps.
- Drives the RUC control pins (ENB, DIR, MODO, D, S_IN) one operation per step.
- Inserts settle cycles between steps to cover the gate-propagation delays of the RUC.
- Reports completion with a one-cycle done pulse, a step count and the final Q.

Parameters:
- SETTLE_CYC, 1: idle cycles inserted after every RUC enable pulse; legal range 0..15.
- CNT_W, 3: width of cmd_count; maximum steps per command is 2^CNT_W-1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_L  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 LOAD, 01 SHL, 10 SHR, 11 ROT.
- cmd_count  in  CNT_W  number of steps (ignored for LOAD).
- cmd_data  in  4  parallel data for LOAD.
- cmd_sin  in  1  serial fill bit for SHL/SHR.
- ENB  out  1  RUC enable, one cycle per step.
- DIR  out  1  RUC direction: 0 left, 1 right.
- MODO  out  2  RUC mode: 00 hold, 01 shift, 10 rotate, 11 load.
- D  out  4  RUC parallel input.
- S_IN  out  1  RUC serial input.
- Q  in  4  RUC parallel output.
- S_OUT  in  1  RUC serial output (unused internally; reserved).
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from accept until done.
- result  out  4  Q captured at completion.
- steps_done  out  CNT_W  steps executed for the last command.

Behaviour:
- Reset (RST_L low, asynchronous) forces:
  - State IDLE; cmd_ready=1.
  - ENB=0, DIR=0, MODO=00, D=0, S_IN=0.
  - done=0, busy=0, result=0, steps_done=0.
- Reset release takes effect synchronously on the next edge.
- States: IDLE, STEP, SETTLE, FINISH.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch op/count/data/sin, busy=1, cmd_ready=0, zero the step counter.
  - LOAD, or count>0 → STEP.
  - SHL/SHR/ROT with count=0 → FINISH directly; no ENB pulse is issued.
- STEP (1 cycle):
  - ENB=1 for exactly this cycle.
  - LOAD: MODO=11, D=latched data.
  - SHL: MODO=01, DIR=0, S_IN=latched sin.
  - SHR: MODO=01, DIR=1, S_IN=latched sin.
  - ROT: MODO=10, DIR=0.
  - Step counter increments.
  - Next state is SETTLE if SETTLE_CYC>0. Otherwise the next state is STEP if more steps remain, else FINISH.
- SETTLE:
  - ENB=0, MODO=00; outputs D/DIR/S_IN held stable.
  - Stays SETTLE_CYC cycles, then goes to STEP if steps remain, else FINISH.
- FINISH (1 cycle):
  - result←Q, steps_done←step counter, done=1, busy=0.
  - Next state IDLE; cmd_ready returns to 1 on the following cycle.
- Step count semantics:
  - LOAD is always exactly 1 step.
  - Shift/rotate issue exactly cmd_count ENB pulses.
  - Example latency: SETTLE_CYC=1 → accept-to-done = 2·count+1 cycles.
- Handshake rules:
  - cmd_ready is deasserted while busy.
  - cmd_valid during busy is ignored; no queuing.
  - Host fields are sampled only at acceptance; later changes have no effect.
- ENB is never high in two consecutive cycles when SETTLE_CYC>0.
- ENB is never high in IDLE, SETTLE or FINISH.
- done and ENB are never high in the same cycle.
- Reset mid-command: abort immediately, with all outputs at reset values. No done pulse; partial RUC state is not restored.
- Counter width: the step counter is CNT_W bits and never wraps, because the command is bounded by max count.

Test Plan:
1. Reset with SETTLE_CYC=1: check all outputs are at reset values. Issue LOAD data=1010 → single ENB pulse with MODO=11, D=1010. done arrives 3 cycles after accept with result=1010 and steps_done=1.
2. After LOAD 0001, issue SHL count=3 sin=0 → 3 ENB pulses, each followed by 1 settle cycle. Result=1000, steps_done=3, done 7 cycles after accept.
3. After LOAD 1001, issue ROT count=4 → result=1001. Then ROT count=1 → result=0011.
4. After LOAD 1111, issue SHR count=2 sin=0 → result=0011, with DIR=1 on every pulse.
5. Issue SHL count=0 → no ENB pulse; done one cycle after accept with steps_done=0. Hold cmd_valid high during busy → no second accept until cmd_ready returns.
6. Assert RST_L low during step 2 of SHL count=5 → outputs go to reset values asynchronously, no done pulse, cmd_ready=1 after release.
